// File: rtl/count_chk_pkg.sv
// Shared encodings for the counter sequence checker: FSM states and sample classes.
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GOOD = 2'd0,
        HOLD = 2'd1,
        BAD  = 2'd2
    } cls_e;

    // consec_err / good_run width; thresholds are limited to 1..7
    localparam int CNT_W = 3;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared by rst or clr.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a counter bus: each qualified sample must be prev+1 (mod 2^WIDTH).
// Counts wraps and errors, enters FAULT after repeated errors, re-locks after a good run.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int ROLL_W       = 8,
    parameter int ERR_W        = 8,
    parameter int FAULT_THRESH = 3,
    parameter int RELOCK_CNT   = 4,
    parameter int ALLOW_HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              sample_en,
    input  logic              clear,
    output logic              wrap_pulse,
    output logic              err_pulse,
    output logic [ROLL_W-1:0] rollovers,
    output logic [ERR_W-1:0]  err_count,
    output logic              locked,
    output logic              fault
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   prev_q;
    logic [CNT_W-1:0]   consec_q, consec_d;
    logic [CNT_W-1:0]   good_q, good_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic               locked_q, fault_q;
    logic [WIDTH-1:0]   exp_val;
    cls_e               cls;

    assign exp_val = prev_q + WIDTH'(1);

    always_comb begin
        if (count_in == exp_val)
            cls = GOOD;
        else if ((ALLOW_HOLD != 0) && (count_in == prev_q))
            cls = HOLD;
        else
            cls = BAD;
    end

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        good_d   = good_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        if (sample_en) begin
            case (state_q)
                LOCKED: begin
                    if (cls == GOOD) begin
                        consec_d = '0;
                        wrap_d   = &prev_q;
                    end else if (cls == BAD) begin
                        err_d    = 1'b1;
                        consec_d = consec_q + CNT_W'(1);
                        if (consec_d >= CNT_W'(FAULT_THRESH)) begin
                            state_d = FAULT;
                            good_d  = '0;
                        end
                    end
                end
                FAULT: begin
                    if (cls == GOOD) begin
                        wrap_d = &prev_q;
                        good_d = good_q + CNT_W'(1);
                        if (good_d >= CNT_W'(RELOCK_CNT)) begin
                            state_d  = LOCKED;
                            consec_d = '0;
                        end
                    end else if (cls == BAD) begin
                        err_d  = 1'b1;
                        good_d = '0;
                    end
                end
                // IDLE and the unused encoding: first sample only seeds prev
                default: state_d = LOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            consec_q <= '0;
            good_q   <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            good_q   <= good_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCKED);
            fault_q  <= (state_d == FAULT);
            if (sample_en)
                prev_q <= count_in;
        end
    end

    sat_counter #(.W(ROLL_W)) u_roll (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (wrap_d),
        .q   (rollovers)
    );

    sat_counter #(.W(ERR_W)) u_err (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (err_d),
        .q   (err_count)
    );

    assign wrap_pulse = wrap_q;
    assign err_pulse  = err_q;
    assign locked     = locked_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: three instances (default, no-hold, 2-bit rollover)
// driven in lockstep and compared against a sample-by-sample behavioural model.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       sample_en = 1'b0;
    logic [3:0] count_in = 4'd0;

    always #5 clk = ~clk;

    logic       w0, e0, l0, f0, w1, e1, l1, f1, w2, e2, l2, f2;
    logic [7:0] roll0, errc0, roll1, errc1, errc2;
    logic [1:0] roll2;

    count_seq_checker dut0 (
        .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .clear(clear),
        .wrap_pulse(w0), .err_pulse(e0), .rollovers(roll0), .err_count(errc0),
        .locked(l0), .fault(f0));

    count_seq_checker #(.ALLOW_HOLD(0)) dut1 (
        .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .clear(clear),
        .wrap_pulse(w1), .err_pulse(e1), .rollovers(roll1), .err_count(errc1),
        .locked(l1), .fault(f1));

    count_seq_checker #(.ROLL_W(2)) dut2 (
        .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .clear(clear),
        .wrap_pulse(w2), .err_pulse(e2), .rollovers(roll2), .err_count(errc2),
        .locked(l2), .fault(f2));

    logic [19:0] obs [3];
    assign obs[0] = {w0, e0, l0, f0, roll0, errc0};
    assign obs[1] = {w1, e1, l1, f1, roll1, errc1};
    assign obs[2] = {w2, e2, l2, f2, 6'd0, roll2, errc2};

    int total = 0;
    int bad   = 0;

    // Behavioural model: 0 = waiting for seed, 1 = locked, 2 = fault
    int m_mode [3], m_prev [3], m_roll [3], m_errc [3], m_consec [3], m_good [3];
    bit m_wrap [3], m_err [3];
    int hold_ok  [3] = '{1, 0, 1};
    int roll_max [3] = '{255, 255, 3};

    function automatic logic [19:0] exp_vec(input int i);
        logic [7:0] r, e;
        r = 8'(m_roll[i]);
        e = 8'(m_errc[i]);
        return {m_wrap[i], m_err[i], m_mode[i] == 1, m_mode[i] == 2, r, e};
    endfunction

    task automatic model_step(input int i, input bit r, input bit c, input bit s, input int v);
        bit is_good, is_hold;
        if (r || c) begin
            m_mode[i] = 0; m_prev[i] = 0; m_roll[i] = 0; m_errc[i] = 0;
            m_consec[i] = 0; m_good[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
            return;
        end
        m_wrap[i] = 0;
        m_err[i]  = 0;
        if (!s) return;
        is_good = (v == (m_prev[i] + 1) % 16);
        is_hold = (hold_ok[i] != 0) && (v == m_prev[i]);
        if (m_mode[i] == 0) begin
            m_mode[i] = 1;
        end else if (is_good) begin
            if (m_prev[i] == 15) begin
                m_wrap[i] = 1;
                if (m_roll[i] < roll_max[i]) m_roll[i]++;
            end
            if (m_mode[i] == 1) m_consec[i] = 0;
            else begin
                m_good[i]++;
                if (m_good[i] >= 4) begin m_mode[i] = 1; m_consec[i] = 0; end
            end
        end else if (!is_hold) begin
            m_err[i] = 1;
            if (m_errc[i] < 255) m_errc[i]++;
            if (m_mode[i] == 1) begin
                m_consec[i]++;
                if (m_consec[i] >= 3) begin m_mode[i] = 2; m_good[i] = 0; end
            end else begin
                m_good[i] = 0;
            end
        end
        m_prev[i] = v;
    endtask

    // One clock: drive, advance model at the edge, leave time at edge+1 for sampling
    task automatic tick(input bit r, input bit c, input bit s, input int v);
        rst = r; clear = c; sample_en = s; count_in = 4'(v);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, r, c, s, v);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 1, 9);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== 20'h0) begin
                bad++; $display("FAIL reset dut%0d got=%h want=%h", i, obs[i], 20'h0);
            end
        end
        tick(0, 0, 1, 5);
        total++;
        if ({l0, w0, e0, errc0} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            bad++; $display("FAIL first_seed got l=%b w=%b e=%b ec=%0d want l=1 w=0 e=0 ec=0",
                            l0, w0, e0, errc0);
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        tick(1, 0, 0, 0);
        for (int k = 0; k < 18; k++) begin
            tick(0, 0, 1, k % 16);
            if (w0) pulses++;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== exp_vec(i)) begin
                    bad++; $display("FAIL wrap_seq dut%0d step%0d got=%h want=%h", i, k, obs[i], exp_vec(i));
                end
            end
            if (k == 16) begin
                total++;
                if (w0 !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%b want=1", w0); end
            end
        end
        total++;
        if ({pulses[7:0], roll0, errc0} !== {8'd1, 8'd1, 8'd0}) begin
            bad++; $display("FAIL wrap_totals got pulses=%0d roll=%0d ec=%0d want 1 1 0", pulses, roll0, errc0);
        end
    endtask

    task automatic test_error();
        int seq [4] = '{3, 4, 9, 10};
        tick(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 1, seq[k]);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== exp_vec(i)) begin
                    bad++; $display("FAIL error_seq dut%0d step%0d got=%h want=%h", i, k, obs[i], exp_vec(i));
                end
            end
            if (k == 2) begin
                total++;
                if ({e0, errc0, l0} !== {1'b1, 8'd1, 1'b1}) begin
                    bad++; $display("FAIL err_pulse got e=%b ec=%0d l=%b want 1 1 1", e0, errc0, l0);
                end
            end
        end
        total++;
        if ({e0, errc0} !== {1'b0, 8'd1}) begin
            bad++; $display("FAIL resync got e=%b ec=%0d want 0 1", e0, errc0);
        end
    endtask

    task automatic test_fault();
        int seq [8] = '{2, 7, 1, 6, 7, 8, 9, 10};
        tick(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, 1, seq[k]);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== exp_vec(i)) begin
                    bad++; $display("FAIL fault_seq dut%0d step%0d got=%h want=%h", i, k, obs[i], exp_vec(i));
                end
            end
            if (k == 3) begin
                total++;
                if ({f0, l0, errc0} !== {1'b1, 1'b0, 8'd3}) begin
                    bad++; $display("FAIL fault_entry got f=%b l=%b ec=%0d want 1 0 3", f0, l0, errc0);
                end
            end
            if (k == 6) begin
                total++;
                if (f0 !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b want=1", f0); end
            end
        end
        total++;
        if ({l0, f0} !== 2'b10) begin
            bad++; $display("FAIL relock got l=%b f=%b want l=1 f=0", l0, f0);
        end
    endtask

    task automatic test_hold();
        int seq [4] = '{4, 4, 4, 5};
        tick(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 1, seq[k]);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== exp_vec(i)) begin
                    bad++; $display("FAIL hold_seq dut%0d step%0d got=%h want=%h", i, k, obs[i], exp_vec(i));
                end
            end
        end
        total++;
        if ({errc0, errc1} !== {8'd0, 8'd2}) begin
            bad++; $display("FAIL hold_counts got hold=%0d nohold=%0d want 0 2", errc0, errc1);
        end
    endtask

    task automatic test_saturate_clear();
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        for (int k = 0; k < 80; k++) tick(0, 0, 1, (k + 1) % 16);
        total++;
        if ({roll2, roll0} !== {2'd3, 8'd5}) begin
            bad++; $display("FAIL rollover_sat got r2=%0d r0=%0d want 3 5", roll2, roll0);
        end
        tick(0, 0, 1, 1);
        tick(0, 1, 1, 2);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== 20'h0) begin
                bad++; $display("FAIL clear dut%0d got=%h want=%h", i, obs[i], 20'h0);
            end
        end
        tick(0, 0, 1, 9);
        tick(0, 0, 1, 3);
        tick(1, 0, 1, 4);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== 20'h0) begin
                bad++; $display("FAIL rst_wins dut%0d got=%h want=%h", i, obs[i], 20'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cur = 0;
        tick(1, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            int r, v;
            bit s, c, rs;
            r  = int'($urandom_range(0, 99));
            s  = (r < 85);
            c  = (r == 99);
            rs = (r == 98);
            r  = int'($urandom_range(0, 99));
            if (r < 72)      v = (cur + 1) % 16;
            else if (r < 84) v = cur;
            else             v = int'($urandom_range(0, 15));
            if (s) cur = v;
            tick(rs, c, s, v);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== exp_vec(i)) begin
                    bad++; $display("FAIL random dut%0d cyc%0d got=%h want=%h", i, k, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) model_step(i, 1, 0, 0, 0);
        test_reset();
        test_wrap();
        test_error();
        test_fault();
        test_hold();
        test_saturate_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
